// File: rtl/exec_stage_mdu.sv
// Execute stage: single-cycle ALU plus iterative RV64M multiply/divide unit.
// Ports: clk/rst, in_valid/in_ready operation handshake, decode fields (alu_op, funct3,
//   funct7b5, is_muldiv, alu_src), operands rd1/rd2/imm, out_valid/out_ready result handshake,
//   registered result with zero flag, busy while a multiply or divide is iterating.
module exec_stage_mdu #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic            funct7b5,
  input  logic            is_muldiv,
  input  logic            alu_src,
  input  logic [XLEN-1:0] rd1,
  input  logic [XLEN-1:0] rd2,
  input  logic [XLEN-1:0] imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            busy
);

  localparam int SH_W = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  typedef enum logic [3:0] {
    C_ADD, C_SUB, C_SLL, C_SLT, C_SLTU, C_XOR, C_SRL, C_SRA, C_OR, C_AND, C_PASSB
  } alu_ctl_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2*XLEN-1:0] acc_q, acc_d;   // mul: {partial hi, multiplier/product lo}; div: {remainder, quotient}
  logic [XLEN-1:0]   b_q;            // mul: |multiplicand|; div: |divisor|
  logic              neg_q, sel_hi_q, is_div_q;
  logic [XLEN-1:0]   result_q;
  logic              out_valid_q;
  logic              accept;

  assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = (result_q == '0);
  assign busy      = (state_q == MUL) || (state_q == DIV);

  // ---------------------------------------------------------------- ALU path
  alu_ctl_t        alu_ctl;
  logic [XLEN-1:0] opb, alu_y;

  assign opb = alu_src ? imm : rd2;

  always_comb begin
    alu_ctl = C_ADD;
    unique case (alu_op)
      2'b00: alu_ctl = C_ADD;    // loads/stores
      2'b01: alu_ctl = C_SUB;    // branches
      2'b10: begin
        unique case (funct3)
          3'b000: alu_ctl = (funct7b5 && !alu_src) ? C_SUB : C_ADD;  // only R-type has SUB
          3'b001: alu_ctl = C_SLL;
          3'b010: alu_ctl = C_SLT;
          3'b011: alu_ctl = C_SLTU;
          3'b100: alu_ctl = C_XOR;
          3'b101: alu_ctl = funct7b5 ? C_SRA : C_SRL;
          3'b110: alu_ctl = C_OR;
          default: alu_ctl = C_AND;
        endcase
      end
      default: alu_ctl = C_PASSB; // LUI-style pass-through
    endcase
  end

  always_comb begin
    alu_y = '0;
    unique case (alu_ctl)
      C_ADD:   alu_y = rd1 + opb;
      C_SUB:   alu_y = rd1 - opb;
      C_SLL:   alu_y = rd1 << opb[SH_W-1:0];
      C_SLT:   alu_y = {{(XLEN-1){1'b0}}, ($signed(rd1) < $signed(opb))};
      C_SLTU:  alu_y = {{(XLEN-1){1'b0}}, (rd1 < opb)};
      C_XOR:   alu_y = rd1 ^ opb;
      C_SRL:   alu_y = rd1 >> opb[SH_W-1:0];
      C_SRA:   alu_y = $unsigned($signed(rd1) >>> opb[SH_W-1:0]);
      C_OR:    alu_y = rd1 | opb;
      C_AND:   alu_y = rd1 & opb;
      default: alu_y = opb;
    endcase
  end

  // ---------------------------------------------------------- M-ext decode
  // Operand B for M ops is always rd2.
  logic            md_is_div, a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            div_zero, div_ovf;
  logic [XLEN-1:0] special_y;

  assign md_is_div = funct3[2];
  assign a_signed  = md_is_div ? !funct3[0] : (funct3 != 3'b011);
  assign b_signed  = md_is_div ? !funct3[0] : !funct3[1];
  assign a_neg     = a_signed && rd1[XLEN-1];
  assign b_neg     = b_signed && rd2[XLEN-1];
  assign a_mag     = a_neg ? (~rd1 + 1'b1) : rd1;
  assign b_mag     = b_neg ? (~rd2 + 1'b1) : rd2;
  assign div_zero  = (rd2 == '0);
  assign div_ovf   = !funct3[0] && (rd1 == {1'b1, {(XLEN-1){1'b0}}}) && (&rd2);

  always_comb begin
    special_y = '0;
    if (div_zero) special_y = funct3[1] ? rd1 : '1;
    else          special_y = funct3[1] ? '0  : rd1;
  end

  // ------------------------------------------------------- iteration steps
  logic [XLEN:0] mul_sum, rem_sh, div_diff;

  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
  assign rem_sh   = acc_q[2*XLEN-1:XLEN-1];
  assign div_diff = rem_sh - {1'b0, b_q};

  always_comb begin
    acc_d = acc_q;
    if (state_q == MUL) begin
      acc_d = {mul_sum, acc_q[XLEN-1:1]};
    end else if (state_q == DIV) begin
      // Restoring step: keep the subtraction only when it did not go negative.
      if (!div_diff[XLEN]) acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      else                 acc_d = {rem_sh[XLEN-1:0],   acc_q[XLEN-2:0], 1'b0};
    end
  end

  // Sign fix-up: the product is negated as a full 2*XLEN value before selecting a half.
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   div_sel, done_y;

  assign prod_s  = neg_q ? (~acc_q + 1'b1) : acc_q;
  assign div_sel = sel_hi_q ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];

  always_comb begin
    done_y = '0;
    if (is_div_q) done_y = neg_q ? (~div_sel + 1'b1) : div_sel;
    else          done_y = sel_hi_q ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
  end

  // ------------------------------------------------------------------ FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      b_q         <= '0;
      neg_q       <= 1'b0;
      sel_hi_q    <= 1'b0;
      is_div_q    <= 1'b0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      // Handoff clears out_valid; a same-edge load below takes priority.
      if (out_ready) out_valid_q <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (accept) begin
            if (!is_muldiv) begin
              result_q    <= alu_y;
              out_valid_q <= 1'b1;
            end else if (md_is_div && (div_zero || div_ovf)) begin
              result_q    <= special_y;
              out_valid_q <= 1'b1;
            end else if (md_is_div) begin
              state_q  <= DIV;
              cnt_q    <= '0;
              acc_q    <= {{XLEN{1'b0}}, a_mag};
              b_q      <= b_mag;
              neg_q    <= funct3[1] ? a_neg : (a_neg ^ b_neg);
              sel_hi_q <= funct3[1];
              is_div_q <= 1'b1;
            end else begin
              state_q  <= MUL;
              cnt_q    <= '0;
              acc_q    <= {{XLEN{1'b0}}, b_mag};
              b_q      <= a_mag;
              neg_q    <= a_neg ^ b_neg;
              sel_hi_q <= (funct3[1:0] != 2'b00);
              is_div_q <= 1'b0;
            end
          end
        end
        MUL, DIV: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(XLEN-1)) state_q <= DONE;
        end
        default: begin // DONE
          result_q    <= done_y;
          out_valid_q <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exec_stage_mdu.sv
module tb_exec_stage_mdu;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready;
  logic [1:0]      alu_op;
  logic [2:0]      funct3;
  logic            funct7b5, is_muldiv, alu_src;
  logic [XLEN-1:0] rd1, rd2, imm;
  logic            out_valid, out_ready;
  logic [XLEN-1:0] result;
  logic            zero, busy;

  int vectors     = 0;
  int miscompares = 0;
  int lat, busy_cnt;

  exec_stage_mdu #(.XLEN(XLEN), .CNT_W(7)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct3(funct3), .funct7b5(funct7b5), .is_muldiv(is_muldiv),
    .alu_src(alu_src), .rd1(rd1), .rd2(rd2), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an op for one cycle (must be accepted); returns right after the accept edge.
  task automatic issue(input logic md, input logic [1:0] aop, input logic [2:0] f3,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] im, input logic src);
    is_muldiv = md; alu_op = aop; funct3 = f3; funct7b5 = md ? 1'b0 : funct7b5;
    rd1 = a; rd2 = b; imm = im; alu_src = src; in_valid = 1'b1;
    #1;
    check("in_ready_at_issue", {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    // Scramble inputs so late sampling of operands would be visible.
    rd1 = 64'hDEAD_BEEF_0BAD_F00D; rd2 = 64'h1234_5678_9ABC_DEF0; funct3 = ~f3;
  endtask

  // Wait for out_valid, counting edges after accept and cycles with busy high.
  task automatic wait_result();
    lat = 0; busy_cnt = 0;
    while (!out_valid && lat < 300) begin
      if (busy) busy_cnt++;
      tick();
      lat++;
    end
    vectors++;
    assert (out_valid === 1'b1) else begin
      miscompares++;
      $error("FAIL timeout observed=%0d expected=<300", lat);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; alu_op = 2'b00; funct3 = 3'b000;
    funct7b5 = 1'b0; is_muldiv = 1'b0; alu_src = 1'b0; rd1 = '0; rd2 = '0; imm = '0;
    tick(); tick();
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_zero", {63'd0, zero}, 64'd1);
    check("rst_busy", {63'd0, busy}, 64'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // ADD 5 + (-7) via immediate: -2, latency 1
    issue(1'b0, 2'b10, 3'b000, 64'd5, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 1'b1);
    check("add_valid", {63'd0, out_valid}, 64'd1);
    check("add_result", result, 64'hFFFF_FFFF_FFFF_FFFE);
    check("add_zero", {63'd0, zero}, 64'd0);
    tick();
    check("add_valid_clears", {63'd0, out_valid}, 64'd0);

    // SUB R-type: 10 - 10 = 0 sets zero
    funct7b5 = 1'b1;
    issue(1'b0, 2'b10, 3'b000, 64'd10, 64'd10, 64'd3, 1'b0);
    funct7b5 = 1'b0;
    check("sub_result", result, 64'd0);
    check("sub_zero", {63'd0, zero}, 64'd1);
    tick();

    // MULH -1 * 1 -> high half all ones, 64 busy cycles, out_valid 65 edges after accept
    issue(1'b1, 2'b10, 3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0);
    wait_result();
    check("mulh_result", result, 64'hFFFF_FFFF_FFFF_FFFF);
    check("mulh_latency", 64'(lat), 64'd65);
    check("mulh_busy_cycles", 64'(busy_cnt), 64'd64);
    tick();

    // MUL 3 * 7 = 21 (alu_src high must be ignored)
    issue(1'b1, 2'b10, 3'b000, 64'd3, 64'd7, 64'd1000, 1'b1);
    wait_result();
    check("mul_result", result, 64'd21);
    tick();

    // MULHU 2^63 * 4 -> high half 2
    issue(1'b1, 2'b10, 3'b011, 64'h8000_0000_0000_0000, 64'd4, 64'd0, 1'b0);
    wait_result();
    check("mulhu_result", result, 64'd2);
    tick();

    // DIV -7 / 2 = -3
    issue(1'b1, 2'b10, 3'b100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'd0, 1'b0);
    wait_result();
    check("div_result", result, 64'hFFFF_FFFF_FFFF_FFFD);
    check("div_latency", 64'(lat), 64'd65);
    tick();

    // REM -7 % 2 = -1
    issue(1'b1, 2'b10, 3'b110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'd0, 1'b0);
    wait_result();
    check("rem_result", result, 64'hFFFF_FFFF_FFFF_FFFF);
    check("rem_latency", 64'(lat), 64'd65);
    tick();

    // REMU 100 % 7 = 2
    issue(1'b1, 2'b10, 3'b111, 64'd100, 64'd7, 64'd0, 1'b0);
    wait_result();
    check("remu_result", result, 64'd2);
    tick();

    // DIVU 9 / 0 -> all ones, latency 1
    issue(1'b1, 2'b10, 3'b101, 64'd9, 64'd0, 64'd0, 1'b0);
    check("divu0_valid", {63'd0, out_valid}, 64'd1);
    check("divu0_result", result, 64'hFFFF_FFFF_FFFF_FFFF);
    check("divu0_busy", {63'd0, busy}, 64'd0);
    tick();

    // REM by zero -> A
    issue(1'b1, 2'b10, 3'b110, 64'd42, 64'd0, 64'd0, 1'b0);
    check("rem0_result", result, 64'd42);
    tick();

    // REM overflow: -2^63 % -1 -> 0, zero=1, latency 1
    issue(1'b1, 2'b10, 3'b110, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0);
    check("removf_valid", {63'd0, out_valid}, 64'd1);
    check("removf_result", result, 64'd0);
    check("removf_zero", {63'd0, zero}, 64'd1);
    tick();

    // DIV overflow -> A
    issue(1'b1, 2'b10, 3'b100, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0);
    check("divovf_result", result, 64'h8000_0000_0000_0000);
    tick();

    // Backpressure: hold MUL result for 5 cycles, then handoff + accept together
    out_ready = 1'b0;
    issue(1'b1, 2'b10, 3'b000, 64'd3, 64'd7, 64'd0, 1'b0);
    wait_result();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid", {63'd0, out_valid}, 64'd1);
      check("hold_result", result, 64'd21);
      check("hold_in_ready", {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    issue(1'b0, 2'b00, 3'b000, 64'd40, 64'd2, 64'd0, 1'b0);
    check("handoff_new_valid", {63'd0, out_valid}, 64'd1);
    check("handoff_new_result", result, 64'd42);
    tick();
    check("handoff_clear", {63'd0, out_valid}, 64'd0);

    // Reset on cycle 30 of a DIV aborts it
    issue(1'b1, 2'b10, 3'b100, 64'd1000, 64'd3, 64'd0, 1'b0);
    for (int i = 0; i < 29; i++) tick();
    check("mid_div_busy", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("abort_in_ready", {63'd0, in_ready}, 64'd1);
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_valid", {63'd0, out_valid}, 64'd0);
    begin
      int seen = 0;
      for (int i = 0; i < 80; i++) begin
        tick();
        if (out_valid || busy) seen++;
      end
      check("abort_no_pulse", 64'(seen), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
